// File: rtl/nonce_dispatcher.sv
// Latches a job blob (byte-reversed), generates a run of nonces and deals blob+nonce work items
// round-robin to CHANNELS valid/ready ports. Optional macro NONCE_DISPATCH_STRIDE_EN adds job_nonce_stride.
module nonce_dispatcher #(
    parameter int unsigned CHANNELS    = 4,
    parameter int unsigned INPUT_WIDTH = 2144,
    parameter int unsigned NONCE_WIDTH = 32,
    parameter int unsigned NONCE_POS   = 39,
    parameter int unsigned COUNT_WIDTH = 32
) (
    input  logic                            input_data_aclk,
    input  logic                            input_data_rst_n,
    input  logic                            job_start,
    input  logic                            job_abort,
    input  logic [INPUT_WIDTH-1:0]          job_blob,
    input  logic [NONCE_WIDTH-1:0]          job_nonce_base,
    input  logic [COUNT_WIDTH-1:0]          job_nonce_count,
`ifdef NONCE_DISPATCH_STRIDE_EN
    input  logic [NONCE_WIDTH-1:0]          job_nonce_stride,
`endif
    output logic [CHANNELS*INPUT_WIDTH-1:0] input_data,
    output logic [CHANNELS*NONCE_WIDTH-1:0] input_data_nonce,
    output logic [CHANNELS-1:0]             input_data_valid,
    input  logic [CHANNELS-1:0]             input_data_ready,
    output logic                            job_busy,
    output logic                            job_done,
    output logic [COUNT_WIDTH-1:0]          job_issued
);

    localparam int unsigned BYTES = INPUT_WIDTH / 8;
    localparam int unsigned RR_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_t;

    state_t                 state;
    logic [INPUT_WIDTH-1:0] blob_rev;
    logic [INPUT_WIDTH-1:0] blob_q;
    logic [INPUT_WIDTH-1:0] work_item;
    logic [NONCE_WIDTH-1:0] next_nonce;
    logic [NONCE_WIDTH-1:0] stride_in;
    logic [NONCE_WIDTH-1:0] stride_q;
    logic [COUNT_WIDTH-1:0] job_count;
    logic [RR_W-1:0]        rr;
    logic [CHANNELS-1:0]    free_mask;
    logic                   load_found;
    logic [RR_W-1:0]        load_ch;
    logic                   drain_clear;

`ifdef NONCE_DISPATCH_STRIDE_EN
    assign stride_in = job_nonce_stride;
`else
    assign stride_in = NONCE_WIDTH'(1);
`endif

    always_comb begin
        blob_rev = '0;
        for (int unsigned i = 0; i < BYTES; i++) begin
            blob_rev[i*8 +: 8] = job_blob[(BYTES-1-i)*8 +: 8];
        end
    end

    always_comb begin
        work_item = blob_q;
        work_item[NONCE_POS*8 +: NONCE_WIDTH] = next_nonce;
    end

    // A slot handshaking this cycle counts as free, giving one nonce per cycle per channel.
    assign free_mask   = ~input_data_valid | input_data_ready;
    assign drain_clear = ((input_data_valid & ~input_data_ready) == '0);
    assign job_busy    = (state != ST_IDLE);

    always_comb begin
        int unsigned idx;
        idx        = 0;
        load_found = 1'b0;
        load_ch    = '0;
        for (int unsigned k = 0; k < CHANNELS; k++) begin
            idx = (32'(rr) + k) % CHANNELS;
            if (!load_found && free_mask[idx]) begin
                load_found = 1'b1;
                load_ch    = RR_W'(idx);
            end
        end
    end

    always_ff @(posedge input_data_aclk or negedge input_data_rst_n) begin
        if (!input_data_rst_n) begin
            state            <= ST_IDLE;
            input_data       <= '0;
            input_data_nonce <= '0;
            input_data_valid <= '0;
            job_done         <= 1'b0;
            job_issued       <= '0;
            blob_q           <= '0;
            next_nonce       <= '0;
            stride_q         <= '0;
            job_count        <= '0;
            rr               <= '0;
        end else begin
            job_done <= 1'b0;
            for (int unsigned c = 0; c < CHANNELS; c++) begin
                if (input_data_valid[c] && input_data_ready[c]) begin
                    input_data_valid[c] <= 1'b0;
                end
            end
            case (state)
                ST_IDLE: begin
                    if (job_start) begin
                        blob_q     <= blob_rev;
                        next_nonce <= job_nonce_base;
                        job_count  <= job_nonce_count;
                        stride_q   <= stride_in;
                        job_issued <= '0;
                        state      <= (job_nonce_count != '0) ? ST_RUN : ST_DONE;
                    end
                end
                ST_RUN: begin
                    if (job_abort) begin
                        state <= ST_DRAIN;
                    end else if (load_found) begin
                        input_data_valid[load_ch]                           <= 1'b1;
                        input_data[32'(load_ch)*INPUT_WIDTH +: INPUT_WIDTH] <= work_item;
                        input_data_nonce[32'(load_ch)*NONCE_WIDTH +: NONCE_WIDTH] <= next_nonce;
                        rr         <= (32'(load_ch) == CHANNELS - 1) ? '0 : load_ch + 1'b1;
                        next_nonce <= next_nonce + stride_q;
                        job_issued <= job_issued + 1'b1;
                        if (COUNT_WIDTH'(job_issued + 1'b1) == job_count) begin
                            state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (drain_clear) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    job_done <= 1'b1;
                    state    <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nonce_dispatcher.sv
// Directed bench for nonce_dispatcher: round-robin dealing, byte reversal, backpressure, wrap, abort,
// zero count and mid-job reset; stride case when NONCE_DISPATCH_STRIDE_EN is defined.
module tb_nonce_dispatcher;

    localparam int unsigned CH = 4;
    localparam int unsigned IW = 2144;
    localparam int unsigned NW = 32;
    localparam int unsigned CW = 32;
    localparam int unsigned NP = 39;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              job_start = 1'b0;
    logic              job_abort = 1'b0;
    logic [IW-1:0]     job_blob = '0;
    logic [NW-1:0]     job_nonce_base = '0;
    logic [CW-1:0]     job_nonce_count = '0;
`ifdef NONCE_DISPATCH_STRIDE_EN
    logic [NW-1:0]     job_nonce_stride = 32'd1;
`endif
    logic [CH*IW-1:0]  input_data;
    logic [CH*NW-1:0]  input_data_nonce;
    logic [CH-1:0]     input_data_valid;
    logic [CH-1:0]     input_data_ready = '1;
    logic              job_busy;
    logic              job_done;
    logic [CW-1:0]     job_issued;

    int n_checks = 0;
    int n_errors = 0;

    nonce_dispatcher #(
        .CHANNELS(CH), .INPUT_WIDTH(IW), .NONCE_WIDTH(NW), .NONCE_POS(NP), .COUNT_WIDTH(CW)
    ) dut (
        .input_data_aclk  (clk),
        .input_data_rst_n (rst_n),
        .job_start        (job_start),
        .job_abort        (job_abort),
        .job_blob         (job_blob),
        .job_nonce_base   (job_nonce_base),
        .job_nonce_count  (job_nonce_count),
`ifdef NONCE_DISPATCH_STRIDE_EN
        .job_nonce_stride (job_nonce_stride),
`endif
        .input_data       (input_data),
        .input_data_nonce (input_data_nonce),
        .input_data_valid (input_data_valid),
        .input_data_ready (input_data_ready),
        .job_busy         (job_busy),
        .job_done         (job_done),
        .job_issued       (job_issued)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [NW-1:0] tag_of(input int c);
        return input_data_nonce[c*NW +: NW];
    endfunction

    function automatic logic [NW-1:0] field_of(input int c);
        return input_data[c*IW + NP*8 +: NW];
    endfunction

    // Drive a start pulse in the current cycle T; returns in cycle T+1.
    task automatic start_job(input logic [NW-1:0] base, input logic [CW-1:0] count);
        job_nonce_base  = base;
        job_nonce_count = count;
        job_start       = 1'b1;
        step();
        job_start       = 1'b0;
    endtask

    int exp_ch  [8];
    int exp_tag [8];
    logic [3:0] exp_vld [8];

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rst_valid",  64'(input_data_valid), 64'h0);
        chk("rst_busy",   64'(job_busy), 64'h0);
        chk("rst_done",   64'(job_done), 64'h0);
        chk("rst_issued", 64'(job_issued), 64'h0);
        chk("rst_nonce",  64'(|input_data_nonce), 64'h0);

        job_abort = 1'b1;
        step();
        step();
        job_abort = 1'b0;
        chk("idle_abort_busy", 64'(job_busy), 64'h0);

        // Basic run with byte-reversal markers
        job_blob = '0;
        job_blob[7:0]     = 8'hAA;
        job_blob[IW-1 -: 8] = 8'h55;
        start_job(32'h10, 8);
        chk("t1_busy", 64'(job_busy), 64'h1);
        for (int k = 2; k <= 9; k++) begin
            int c;
            step();
            c = (k - 2) % 4;
            chk("t1_valid", 64'(input_data_valid), 64'(4'b0001 << c));
            chk("t1_tag",   64'(tag_of(c)), 64'(32'h10 + k - 2));
            chk("t1_field", 64'(field_of(c)), 64'(32'h10 + k - 2));
            if (k == 2) begin
                chk("t1_top_byte", 64'(input_data[IW-1 -: 8]), 64'hAA);
                chk("t1_bot_byte", 64'(input_data[7:0]), 64'h55);
            end
        end
        step();
        chk("t1_t10_valid", 64'(input_data_valid), 64'h0);
        chk("t1_t10_done",  64'(job_done), 64'h0);
        chk("t1_t10_busy",  64'(job_busy), 64'h1);
        step();
        chk("t1_done",   64'(job_done), 64'h1);
        chk("t1_issued", 64'(job_issued), 64'd8);
        step();
        chk("t1_done_pulse", 64'(job_done), 64'h0);
        chk("t1_idle",       64'(job_busy), 64'h0);

        // Backpressure on ch1
        exp_vld[2] = 4'b0001; exp_ch[2] = 0; exp_tag[2] = 32'h100;
        exp_vld[3] = 4'b0010; exp_ch[3] = 1; exp_tag[3] = 32'h101;
        exp_vld[4] = 4'b0110; exp_ch[4] = 2; exp_tag[4] = 32'h102;
        exp_vld[5] = 4'b1010; exp_ch[5] = 3; exp_tag[5] = 32'h103;
        exp_vld[6] = 4'b0011; exp_ch[6] = 0; exp_tag[6] = 32'h104;
        exp_vld[7] = 4'b0110; exp_ch[7] = 2; exp_tag[7] = 32'h105;
        input_data_ready = 4'b1101;
        start_job(32'h100, 6);
        for (int k = 2; k <= 7; k++) begin
            step();
            chk("t2_valid", 64'(input_data_valid), 64'(exp_vld[k]));
            chk("t2_tag",   64'(tag_of(exp_ch[k])), 64'(exp_tag[k]));
        end
        step();
        chk("t2_hold_valid", 64'(input_data_valid), 64'b0010);
        chk("t2_hold_tag",   64'(tag_of(1)), 64'h101);
        job_nonce_base  = 32'h999;
        job_nonce_count = 0;
        job_start       = 1'b1;
        step();
        job_start = 1'b0;
        chk("t2_hold_valid2", 64'(input_data_valid), 64'b0010);
        chk("t2_hold_tag2",   64'(tag_of(1)), 64'h101);
        chk("t2_hold_field",  64'(field_of(1)), 64'h101);
        chk("t2_busy",        64'(job_busy), 64'h1);
        chk("t2_no_done",     64'(job_done), 64'h0);
        step();
        chk("t2_hold_valid3", 64'(input_data_valid), 64'b0010);
        input_data_ready = 4'b1111;
        step();
        chk("t2_drained", 64'(input_data_valid), 64'h0);
        chk("t2_done_lo", 64'(job_done), 64'h0);
        step();
        chk("t2_done",   64'(job_done), 64'h1);
        chk("t2_issued", 64'(job_issued), 64'd6);

        // Nonce wrap; rr left at 3 by previous job
        start_job(32'hFFFF_FFFE, 3);
        step();
        chk("t3_tag0", 64'(tag_of(3)), 64'hFFFF_FFFE);
        chk("t3_vld0", 64'(input_data_valid), 64'b1000);
        step();
        chk("t3_tag1", 64'(tag_of(0)), 64'hFFFF_FFFF);
        step();
        chk("t3_tag2",   64'(tag_of(1)), 64'h0);
        chk("t3_field2", 64'(field_of(1)), 64'h0);
        step();
        step();
        chk("t3_done",   64'(job_done), 64'h1);
        chk("t3_issued", 64'(job_issued), 64'd3);

        // Abort after 5 issues; rr at 2
        start_job(32'h200, 100);
        for (int k = 2; k <= 6; k++) begin
            int c;
            step();
            c = k % 4;
            chk("t4_tag",   64'(tag_of(c)), 64'(32'h200 + k - 2));
            chk("t4_valid", 64'(input_data_valid), 64'(4'b0001 << c));
        end
        job_abort = 1'b1;
        step();
        job_abort = 1'b0;
        chk("t4_no_load", 64'(input_data_valid), 64'h0);
        chk("t4_busy",    64'(job_busy), 64'h1);
        chk("t4_issued",  64'(job_issued), 64'd5);
        step();
        chk("t4_done_lo", 64'(job_done), 64'h0);
        step();
        chk("t4_done",        64'(job_done), 64'h1);
        chk("t4_issued_fin",  64'(job_issued), 64'd5);

        // Zero count
        start_job(32'h300, 0);
        chk("t5_busy",    64'(job_busy), 64'h1);
        chk("t5_done_lo", 64'(job_done), 64'h0);
        step();
        chk("t5_done",   64'(job_done), 64'h1);
        chk("t5_valid",  64'(input_data_valid), 64'h0);
        chk("t5_issued", 64'(job_issued), 64'h0);
        step();
        chk("t5_done_pulse", 64'(job_done), 64'h0);
        chk("t5_idle",       64'(job_busy), 64'h0);

`ifdef NONCE_DISPATCH_STRIDE_EN
        // Stride 4 from base 0; rr at 3
        job_nonce_stride = 32'd4;
        start_job(32'h0, 4);
        for (int k = 2; k <= 5; k++) begin
            step();
            chk("t6_tag", 64'(tag_of((k + 1) % 4)), 64'(4 * (k - 2)));
        end
        step();
        step();
        chk("t6_done", 64'(job_done), 64'h1);
        job_nonce_stride = 32'd1;
`endif

        // Asynchronous reset mid-job
        start_job(32'h400, 100);
        step();
        step();
        chk("t7_running", 64'(input_data_valid != 0), 64'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("t7_rst_valid",  64'(input_data_valid), 64'h0);
        chk("t7_rst_busy",   64'(job_busy), 64'h0);
        chk("t7_rst_issued", 64'(job_issued), 64'h0);
        chk("t7_rst_nonce",  64'(|input_data_nonce), 64'h0);
        step();
        rst_n = 1'b1;
        step();
        chk("t7_idle", 64'(job_busy), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
